mem_io_unit: RTL and testbench
==============================

Name: mem_io_unit

Overview:
- LC-3 datapath memory/IO interface owning MAR and MDR.
- Loads MAR/MDR from the datapath BUS, sequences asynchronous SRAM reads and writes with configurable wait states, and returns read data in MDR for GateMDR to drive back onto BUS.
- Address 16'hFFFF is memory-mapped I/O: reads return the switch inputs, writes update the hex-display register.
- It is the BUS-driving counterpart to the register file, which only sinks BUS.

Parameters:
WAIT_STATES, 2, SRAM access cycles per read/write; legal range 1..15.
IO_ADDR, 16'hFFFF, MAR value decoded as the switch/hex I/O port.

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
BUS  input  16  datapath bus, source for MAR/MDR loads
LD_MAR  input  1  load MAR from BUS (honoured only in IDLE)
LD_MDR  input  1  load MDR from BUS (honoured only in IDLE)
MEM_EN  input  1  access request, level; held by controller until R seen
MEM_WE  input  1  sampled with MEM_EN in IDLE: 1 = write, 0 = read
Switches  input  16  I/O read source for IO_ADDR
Data_from_SRAM  input  16  SRAM read data
MAR  output  16  address register, also SRAM address
MDR  output  16  data register (goes to BUS via external GateMDR mux)
R  output  1  ready, one-cycle pulse on access completion
Data_to_SRAM  output  16  equals MDR
CE_N  output  1  SRAM chip enable, active low
OE_N  output  1  SRAM output enable, active low
WE_N  output  1  SRAM write enable, active low
HEX_OUT  output  16  I/O display register

Behaviour:
- Reset (sync) values: MAR=0, MDR=0, HEX_OUT=0, R=0, CE_N=OE_N=WE_N=1, state=IDLE, wait counter=0. Reset asserted mid-access aborts the access: no MDR/HEX update and no R pulse.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - LD_MAR: MAR<=BUS. LD_MDR: MDR<=BUS. Both may load in the same cycle.
  - MEM_EN=1 at an edge: counter<=0, go to WR_WAIT if MEM_WE else RD_WAIT.
  - LD_* and MEM_EN together at the same edge: the loads take effect and the access uses the newly loaded MAR/MDR. The access latches MAR/MDR on the following edge; SRAM pins are driven from the registers during WAIT.
- RD_WAIT:
  - CE_N=0 if MAR!=IO_ADDR, else 1. OE_N=0 (only when CE_N=0). WE_N=1.
  - Counter increments each edge.
  - When counter==WAIT_STATES-1 at an edge: MDR<=(MAR==IO_ADDR ? Switches : Data_from_SRAM), go to DONE.
- WR_WAIT:
  - CE_N as in RD_WAIT, OE_N=1, WE_N=0 (only when CE_N=0). Data_to_SRAM=MDR throughout.
  - At terminal count: if MAR==IO_ADDR then HEX_OUT<=MDR. Go to DONE.
- DONE: R=1 for exactly this cycle, all enables high. Next edge goes to IDLE unconditionally.
- LD_MAR/LD_MDR are ignored outside IDLE; MAR and MDR are stable for the whole access.
- Latency: MEM_EN sampled at edge k gives R high in the cycle after edge k+WAIT_STATES. Access-to-access minimum is WAIT_STATES+2 cycles.
- MEM_EN still high in IDLE after DONE starts a new access (back-to-back is legal; the controller drops MEM_EN on R to avoid it).
- MEM_WE is sampled only at the IDLE->WAIT edge; changes mid-access are ignored.
- WE_N and OE_N are never both 0.
- All outputs are registered or decoded from state only; no combinational path from inputs to CE_N/OE_N/WE_N.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles -> MAR=MDR=HEX_OUT=0, R=0, CE_N=OE_N=WE_N=1.
- SRAM read, WAIT_STATES=2: BUS=16'h3000 with LD_MAR, then MEM_EN=1/MEM_WE=0, Data_from_SRAM=16'hBEEF -> CE_N=OE_N=0 for 2 cycles, R pulses 1 cycle at edge k+2, MDR=16'hBEEF, WE_N stays 1.
- SRAM write: MAR=16'h3001, MDR=16'h1234, MEM_EN=1/MEM_WE=1 -> WE_N=0 and CE_N=0 for 2 cycles, Data_to_SRAM=16'h1234, OE_N=1, R pulse, HEX_OUT unchanged.
- I/O: MAR=16'hFFFF, Switches=16'h00A5, read -> MDR=16'h00A5, CE_N=1 throughout. Then MDR=16'h0042, write -> HEX_OUT=16'h0042, WE_N=1.
- Blocked loads: during RD_WAIT, LD_MAR with BUS=16'h5555 and LD_MDR with BUS=16'h6666 -> MAR unchanged; MDR equals the SRAM data at DONE.
- Abort plus back-to-back: Reset asserted in the 1st RD_WAIT cycle -> no R, MDR=0, IDLE next cycle. Separately, MEM_EN held high across two reads -> R pulses exactly every WAIT_STATES+2 cycles.

Source files
------------

// File: rtl/mem_io_unit.sv
// LC-3 memory/IO interface: owns MAR/MDR, sequences async SRAM accesses with
// fixed wait states, and maps IO_ADDR onto the switch inputs and hex display.
module mem_io_unit #(
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] BUS,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MEM_EN,
  input  logic        MEM_WE,
  input  logic [15:0] Switches,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic        R,
  output logic [15:0] Data_to_SRAM,
  output logic        CE_N,
  output logic        OE_N,
  output logic        WE_N,
  output logic [15:0] HEX_OUT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] hex_q, hex_d;
  logic        r_q, r_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        sram_sel_d;
  logic        is_io_q;

  assign is_io_q = (mar_q == IO_ADDR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    hex_d   = hex_q;

    case (state_q)
      IDLE: begin
        if (LD_MAR) mar_d = BUS;
        if (LD_MDR) mdr_d = BUS;
        if (MEM_EN) begin
          cnt_d   = 4'd0;
          state_d = MEM_WE ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          mdr_d   = is_io_q ? Switches : Data_from_SRAM;
          cnt_d   = 4'd0;
          state_d = DONE;
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          if (is_io_q) hex_d = mdr_q;
          cnt_d   = 4'd0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are computed from the next state and next MAR so the pins are
    // pure flops and the I/O port never touches the SRAM.
    sram_sel_d = ((state_d == RD_WAIT) || (state_d == WR_WAIT)) &&
                 (mar_d != IO_ADDR);
    ce_n_d     = ~sram_sel_d;
    oe_n_d     = ~(sram_sel_d && (state_d == RD_WAIT));
    we_n_d     = ~(sram_sel_d && (state_d == WR_WAIT));
    r_d        = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
      hex_q   <= 16'h0000;
      r_q     <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      hex_q   <= hex_d;
      r_q     <= r_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign MAR          = mar_q;
  assign MDR          = mdr_q;
  assign Data_to_SRAM = mdr_q;
  assign HEX_OUT      = hex_q;
  assign R            = r_q;
  assign CE_N         = ce_n_q;
  assign OE_N         = oe_n_q;
  assign WE_N         = we_n_q;

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed bench for mem_io_unit: reset, SRAM read/write, I/O port,
// blocked loads, reset abort and back-to-back accesses.
module tb_mem_io_unit;

  localparam int WS = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] BUS;
  logic        LD_MAR, LD_MDR, MEM_EN, MEM_WE;
  logic [15:0] Switches, Data_from_SRAM;
  logic [15:0] MAR, MDR, Data_to_SRAM, HEX_OUT;
  logic        R, CE_N, OE_N, WE_N;

  int checks = 0;
  int errors = 0;

  mem_io_unit #(.WAIT_STATES(WS), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .BUS(BUS), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .Switches(Switches),
    .Data_from_SRAM(Data_from_SRAM), .MAR(MAR), .MDR(MDR), .R(R),
    .Data_to_SRAM(Data_to_SRAM), .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N),
    .HEX_OUT(HEX_OUT)
  );

  always #5 Clk = ~Clk;

  // OE_N and WE_N must never be low together.
  always @(negedge Clk) begin
    checks++;
    if (!OE_N && !WE_N) begin
      errors++;
      $display("FAIL oe_we_overlap: OE_N=%b WE_N=%b required not both 0", OE_N, WE_N);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_mar(input logic [15:0] v);
    BUS = v; LD_MAR = 1'b1; tick(); LD_MAR = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    BUS = v; LD_MDR = 1'b1; tick(); LD_MDR = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; tick(); tick(); Reset = 1'b0;
    checks++;
    if (MAR !== 16'h0 || MDR !== 16'h0 || HEX_OUT !== 16'h0 || R !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: MAR=%h MDR=%h HEX=%h R=%b required 0", MAR, MDR, HEX_OUT, R);
    end
    checks++;
    if ({CE_N, OE_N, WE_N} !== 3'b111) begin
      errors++;
      $display("FAIL reset_enables: CE/OE/WE=%b required 111", {CE_N, OE_N, WE_N});
    end
  endtask

  task automatic test_sram_read();
    load_mar(16'h3000);
    Data_from_SRAM = 16'hBEEF; MEM_WE = 1'b0; MEM_EN = 1'b1;
    tick();
    for (int i = 0; i < WS; i++) begin
      checks++;
      if ({CE_N, OE_N, WE_N, R} !== 4'b0010) begin
        errors++;
        $display("FAIL read_wait%0d: CE/OE/WE/R=%b required 0010", i, {CE_N, OE_N, WE_N, R});
      end
      if (i < WS - 1) tick();
    end
    tick();
    MEM_EN = 1'b0;
    checks++;
    if (R !== 1'b1 || MDR !== 16'hBEEF || {CE_N, OE_N, WE_N} !== 3'b111) begin
      errors++;
      $display("FAIL read_done: R=%b MDR=%h en=%b required 1 BEEF 111", R, MDR, {CE_N, OE_N, WE_N});
    end
    tick();
    checks++;
    if (R !== 1'b0) begin
      errors++;
      $display("FAIL read_r_width: R=%b required 0", R);
    end
  endtask

  task automatic test_sram_write();
    load_mar(16'h3001);
    load_mdr(16'h1234);
    MEM_WE = 1'b1; MEM_EN = 1'b1;
    tick();
    MEM_WE = 1'b0;
    for (int i = 0; i < WS; i++) begin
      checks++;
      if ({CE_N, OE_N, WE_N, R} !== 4'b0100 || Data_to_SRAM !== 16'h1234) begin
        errors++;
        $display("FAIL write_wait%0d: CE/OE/WE/R=%b data=%h required 0100 1234", i, {CE_N, OE_N, WE_N, R}, Data_to_SRAM);
      end
      if (i < WS - 1) tick();
    end
    tick();
    MEM_EN = 1'b0;
    checks++;
    if (R !== 1'b1 || HEX_OUT !== 16'h0 || WE_N !== 1'b1) begin
      errors++;
      $display("FAIL write_done: R=%b HEX=%h WE_N=%b required 1 0000 1", R, HEX_OUT, WE_N);
    end
    tick();
  endtask

  task automatic test_io();
    load_mar(16'hFFFF);
    Switches = 16'h00A5; Data_from_SRAM = 16'hDEAD; MEM_WE = 1'b0; MEM_EN = 1'b1;
    tick();
    for (int i = 0; i < WS; i++) begin
      checks++;
      if ({CE_N, OE_N, WE_N} !== 3'b111) begin
        errors++;
        $display("FAIL io_read_wait%0d: CE/OE/WE=%b required 111", i, {CE_N, OE_N, WE_N});
      end
      if (i < WS - 1) tick();
    end
    tick();
    MEM_EN = 1'b0;
    checks++;
    if (R !== 1'b1 || MDR !== 16'h00A5) begin
      errors++;
      $display("FAIL io_read_done: R=%b MDR=%h required 1 00A5", R, MDR);
    end
    tick();
    load_mdr(16'h0042);
    MEM_WE = 1'b1; MEM_EN = 1'b1;
    tick();
    for (int i = 0; i < WS; i++) begin
      checks++;
      if ({CE_N, OE_N, WE_N} !== 3'b111 || HEX_OUT !== 16'h0) begin
        errors++;
        $display("FAIL io_write_wait%0d: CE/OE/WE=%b HEX=%h required 111 0000", i, {CE_N, OE_N, WE_N}, HEX_OUT);
      end
      if (i < WS - 1) tick();
    end
    tick();
    MEM_EN = 1'b0; MEM_WE = 1'b0;
    checks++;
    if (R !== 1'b1 || HEX_OUT !== 16'h0042) begin
      errors++;
      $display("FAIL io_write_done: R=%b HEX=%h required 1 0042", R, HEX_OUT);
    end
    tick();
  endtask

  task automatic test_blocked_loads();
    // Load and access start on the same edge; the access must use the new MAR.
    BUS = 16'h4000; LD_MAR = 1'b1; MEM_EN = 1'b1; MEM_WE = 1'b0;
    Data_from_SRAM = 16'hCAFE;
    tick();
    checks++;
    if (MAR !== 16'h4000 || CE_N !== 1'b0 || OE_N !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_load: MAR=%h CE_N=%b OE_N=%b required 4000 0 0", MAR, CE_N, OE_N);
    end
    BUS = 16'h5555; LD_MAR = 1'b1;
    tick();
    checks++;
    if (MAR !== 16'h4000 || MDR !== 16'h0042) begin
      errors++;
      $display("FAIL blocked_mar: MAR=%h MDR=%h required 4000 0042", MAR, MDR);
    end
    BUS = 16'h6666; LD_MAR = 1'b0; LD_MDR = 1'b1;
    tick();
    LD_MDR = 1'b0; MEM_EN = 1'b0;
    checks++;
    if (R !== 1'b1 || MDR !== 16'hCAFE || MAR !== 16'h4000) begin
      errors++;
      $display("FAIL blocked_done: R=%b MDR=%h MAR=%h required 1 CAFE 4000", R, MDR, MAR);
    end
    tick();
  endtask

  task automatic test_abort();
    Data_from_SRAM = 16'h1111; MEM_WE = 1'b0; MEM_EN = 1'b1;
    tick();
    checks++;
    if (CE_N !== 1'b0) begin
      errors++;
      $display("FAIL abort_started: CE_N=%b required 0", CE_N);
    end
    Reset = 1'b1; MEM_EN = 1'b0;
    tick();
    Reset = 1'b0;
    checks++;
    if (R !== 1'b0 || MDR !== 16'h0 || {CE_N, OE_N, WE_N} !== 3'b111) begin
      errors++;
      $display("FAIL abort_reset: R=%b MDR=%h en=%b required 0 0000 111", R, MDR, {CE_N, OE_N, WE_N});
    end
    BUS = 16'h2000; LD_MAR = 1'b1;
    tick();
    LD_MAR = 1'b0;
    checks++;
    if (R !== 1'b0 || MAR !== 16'h2000 || MDR !== 16'h0) begin
      errors++;
      $display("FAIL abort_idle: R=%b MAR=%h MDR=%h required 0 2000 0000", R, MAR, MDR);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    Data_from_SRAM = 16'h7777; MEM_WE = 1'b0; MEM_EN = 1'b1;
    tick();
    for (int c = 0; c < 3 * (WS + 2); c++) begin
      checks++;
      if (R !== ((c % (WS + 2)) == WS)) begin
        errors++;
        $display("FAIL b2b_r_cycle%0d: R=%b required %b", c, R, ((c % (WS + 2)) == WS));
      end
      if (R === 1'b1) pulses++;
      if (c < 3 * (WS + 2) - 1) tick();
    end
    MEM_EN = 1'b0;
    checks++;
    if (pulses != 3 || MDR !== 16'h7777) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d MDR=%h required 3 7777", pulses, MDR);
    end
    tick(); tick();
    checks++;
    if (R !== 1'b0 || {CE_N, OE_N, WE_N} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_quiet: R=%b en=%b required 0 111", R, {CE_N, OE_N, WE_N});
    end
  endtask

  initial begin
    Reset = 1'b1; BUS = 16'h0; LD_MAR = 1'b0; LD_MDR = 1'b0;
    MEM_EN = 1'b0; MEM_WE = 1'b0; Switches = 16'h0; Data_from_SRAM = 16'h0;
    test_reset();
    test_sram_read();
    test_sram_write();
    test_io();
    test_blocked_loads();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
